// File: rtl/mod2n1_ling_adder_pipe.sv
// mod2n1_ling_adder_pipe: pipelined Ling prefix adder, modulo 2^N-1 (end-around carry)
// or plain 2^N binary add with carry-in/carry-out, valid/ready with global stall.
module mod2n1_ling_adder_pipe #(
    parameter int N           = 8,
    parameter int PIPE_PREFIX = 1,
    parameter int ZERO_NORM   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int LG = $clog2(N);

    typedef struct packed {
        logic         v;
        logic         m;
        logic         ci;
        logic [N-1:0] h;
        logic [N-1:0] pr;
        logic [N-1:0] p;
        logic [N-1:0] x;
    } stage_t;

    logic         en;
    logic [N-1:0] hf, c, sum_raw, sum_d, sum_q;
    logic         cout_d, cout_q, out_valid_d, out_valid_q;
    stage_t       fin;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k <= LG; k++) begin : g_st
        stage_t st_d, st_q;
        if (k == 0) begin : g_in
            // Ling seeds: H_i = g_i, Pr_i = p_{i-1}; bit 0 wraps to p_{N-1} or sees p_{-1}=1
            assign st_d.v  = in_valid;
            assign st_d.m  = mode;
            assign st_d.ci = cin;
            assign st_d.h  = a & b;
            assign st_d.p  = a | b;
            assign st_d.x  = a ^ b;
            assign st_d.pr = {a[N-2:0] | b[N-2:0], mode ? (a[N-1] | b[N-1]) : 1'b1};
        end else begin : g_lvl
            localparam int S = 1 << (k - 1);
            stage_t s;
            assign s = g_st[k-1].st_q;
            assign {st_d.v, st_d.m, st_d.ci, st_d.p, st_d.x} = {s.v, s.m, s.ci, s.p, s.x};
            for (genvar i = 0; i < N; i++) begin : g_b
                localparam int J = (i + N - S) % N;
                logic w;
                // below bit 0 the span wraps in modulo mode, otherwise combines with identity
                assign w          = (i >= S) | s.m;
                assign st_d.h[i]  = s.h[i] | (s.pr[i] & w & s.h[J]);
                assign st_d.pr[i] = s.pr[i] & (~w | s.pr[J]);
            end
        end
        if (k == 0 || PIPE_PREFIX != 0) begin : g_reg
            always_ff @(posedge clk or posedge rst)
                if (rst) st_q <= '0;
                else if (en) st_q <= st_d;
        end else begin : g_comb
            assign st_q = st_d;
        end
    end

    assign fin = g_st[LG].st_q;

    // carry c_i = p_i & h_i; binary mode folds cin in through the remaining group propagate
    always_comb begin
        hf          = fin.h | (fin.m ? '0 : fin.pr & {N{fin.ci}});
        c           = fin.p & hf;
        sum_raw     = fin.x ^ {c[N-2:0], fin.m ? c[N-1] : fin.ci};
        sum_d       = (ZERO_NORM != 0 && fin.m && &sum_raw) ? '0 : sum_raw;
        cout_d      = ~fin.m & c[N-1];
        out_valid_d = fin.v;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
        end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_mod2n1_ling_adder_pipe.sv
// tb_mod2n1_ling_adder_pipe: directed, streaming, backpressure, reset and exhaustive
// modulo checks across N=4/8/16 and both prefix pipelining options.
module tb_mod2n1_ling_adder_pipe;
    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        mode = 0, cin = 0;
    logic        iv8 = 0, ivz = 0, iv4 = 0, iv16 = 0, or8 = 1;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [15:0] a16 = 0, b16 = 0;

    logic        ir8, ov8, c8, irz, ovz, cz;
    logic [7:0]  s8, sz;
    logic        ir4a, ov4a, c4a, ir4b, ov4b, c4b;
    logic [3:0]  s4a, s4b;
    logic        ir16, ov16, c16;
    logic [15:0] s16;

    mod2n1_ling_adder_pipe #(.N(8), .PIPE_PREFIX(1), .ZERO_NORM(0)) d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .mode(mode), .a(a8), .b(b8),
        .cin(cin), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(c8));
    mod2n1_ling_adder_pipe #(.N(8), .PIPE_PREFIX(0), .ZERO_NORM(1)) dz (
        .clk(clk), .rst(rst), .in_valid(ivz), .in_ready(irz), .mode(mode), .a(a8), .b(b8),
        .cin(cin), .out_valid(ovz), .out_ready(1'b1), .sum(sz), .cout(cz));
    mod2n1_ling_adder_pipe #(.N(4), .PIPE_PREFIX(1), .ZERO_NORM(0)) d4a (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4a), .mode(mode), .a(a4), .b(b4),
        .cin(cin), .out_valid(ov4a), .out_ready(1'b1), .sum(s4a), .cout(c4a));
    mod2n1_ling_adder_pipe #(.N(4), .PIPE_PREFIX(0), .ZERO_NORM(0)) d4b (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4b), .mode(mode), .a(a4), .b(b4),
        .cin(cin), .out_valid(ov4b), .out_ready(1'b1), .sum(s4b), .cout(c4b));
    mod2n1_ling_adder_pipe #(.N(16), .PIPE_PREFIX(1), .ZERO_NORM(0)) d16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .mode(mode), .a(a16), .b(b16),
        .cin(cin), .out_valid(ov16), .out_ready(1'b1), .sum(s16), .cout(c16));

    // directed vectors: mode, a, b, cin, {cout,sum} for ZERO_NORM=0 and for ZERO_NORM=1
    bit         tm  [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [7:0] ta  [13] = '{8'h80, 8'h0F, 8'hFF, 8'h00, 8'h12, 8'hC8, 8'h01, 8'hFF,
                             8'hFF, 8'h7F, 8'hFF, 8'h55, 8'hF0};
    logic [7:0] tbv [13] = '{8'h80, 8'hF0, 8'hFF, 8'h00, 8'h34, 8'h64, 8'hFE, 8'h01,
                             8'h01, 8'h00, 8'hFF, 8'hAA, 8'h0F};
    bit         tc  [13] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1};
    logic [8:0] te  [13] = '{9'h001, 9'h0FF, 9'h0FF, 9'h000, 9'h046, 9'h02D, 9'h0FF, 9'h001,
                             9'h100, 9'h080, 9'h1FF, 9'h0FF, 9'h100};
    logic [8:0] tz  [13] = '{9'h001, 9'h000, 9'h000, 9'h000, 9'h046, 9'h02D, 9'h000, 9'h001,
                             9'h100, 9'h080, 9'h1FF, 9'h0FF, 9'h100};

    // reference: {cout,sum}; modulo maps nonzero sums onto 1..2^n-1 (all-ones kept unless zn)
    function automatic int gold(int n, bit m, int a, int b, bit ci, bit zn);
        int s = a + b;
        int mx = (1 << n) - 1;
        if (!m) return s + int'(ci);
        s = (s == 0) ? 0 : (s - 1) % mx + 1;
        return (zn && s == mx) ? 0 : s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        #2;
        n_cmp++;
        if (ov8 !== 1'b0 || s8 !== 8'h00 || c8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b s=%h c=%b, want v=0 s=00 c=0", ov8, s8, c8);
        end
        n_cmp++;
        if (ir8 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", ir8);
        end
        n_cmp++;
        if ({ovz, ov4a, ov4b, ov16} !== 4'b0 || {irz, ir4a, ir4b, ir16} !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_others: got ov=%b ir=%b want 0000/1111",
                     {ovz, ov4a, ov4b, ov16}, {irz, ir4a, ir4b, ir16});
        end
        repeat (2) tick;
        #2 rst = 0;
        tick;
    endtask

    task automatic test_directed;
        for (int e = 0; e < 13; e++) begin
            int l8, lz;
            logic [8:0] r8, rz;
            l8 = 0; lz = 0; r8 = '0; rz = '0;
            mode = tm[e]; a8 = ta[e]; b8 = tbv[e]; cin = tc[e];
            iv8 = 1; ivz = 1;
            for (int k = 1; k <= 8; k++) begin
                tick;
                iv8 = 0; ivz = 0;
                if (ov8 && l8 == 0) begin l8 = k; r8 = {c8, s8}; end
                if (ovz && lz == 0) begin lz = k; rz = {cz, sz}; end
            end
            n_cmp += 2;
            if (l8 != 5 || r8 !== te[e]) begin
                n_bad++;
                $display("FAIL directed_%0d pipe: got lat=%0d res=%h want lat=5 res=%h", e, l8, r8, te[e]);
            end
            if (lz != 2 || rz !== tz[e]) begin
                n_bad++;
                $display("FAIL directed_%0d comb_zn: got lat=%0d res=%h want lat=2 res=%h", e, lz, rz, tz[e]);
            end
        end
    endtask

    task automatic test_stream;
        logic [7:0] sa [256];
        logic [7:0] sb [256];
        bit sm [256];
        bit sc [256];
        int k8 = 0;
        int kz = 0;
        for (int i = 0; i < 256; i++) begin
            sa[i] = 8'($urandom); sb[i] = 8'($urandom);
            sm[i] = 1'($urandom); sc[i] = 1'($urandom);
        end
        for (int t = 0; t < 270; t++) begin
            iv8 = t < 256; ivz = t < 256;
            if (t < 256) begin mode = sm[t]; a8 = sa[t]; b8 = sb[t]; cin = sc[t]; end
            if (ov8) begin
                n_cmp++;
                if (k8 >= 256 || t != k8 + 5 ||
                    {c8, s8} !== 9'(gold(8, sm[k8 % 256], sa[k8 % 256], sb[k8 % 256], sc[k8 % 256], 0))) begin
                    n_bad++;
                    $display("FAIL stream_pipe #%0d: got res=%h at cycle %0d want res=%h at cycle %0d", k8,
                             {c8, s8}, t, 9'(gold(8, sm[k8 % 256], sa[k8 % 256], sb[k8 % 256], sc[k8 % 256], 0)), k8 + 5);
                end
                k8++;
            end
            if (ovz) begin
                n_cmp++;
                if (kz >= 256 || t != kz + 2 ||
                    {cz, sz} !== 9'(gold(8, sm[kz % 256], sa[kz % 256], sb[kz % 256], sc[kz % 256], 1))) begin
                    n_bad++;
                    $display("FAIL stream_comb #%0d: got res=%h at cycle %0d want res=%h at cycle %0d", kz,
                             {cz, sz}, t, 9'(gold(8, sm[kz % 256], sa[kz % 256], sb[kz % 256], sc[kz % 256], 1)), kz + 2);
                end
                kz++;
            end
            tick;
        end
        iv8 = 0; ivz = 0;
        n_cmp++;
        if (k8 != 256 || kz != 256) begin
            n_bad++;
            $display("FAIL stream_count: got %0d/%0d want 256/256", k8, kz);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] pa [12];
        logic [7:0] pb [12];
        bit pm [12];
        bit pc [12];
        int i = 0;
        int k = 0;
        int extra = 0;
        for (int j = 0; j < 12; j++) begin
            pa[j] = 8'($urandom); pb[j] = 8'($urandom); pm[j] = 1'($urandom); pc[j] = 1'($urandom);
        end
        for (int t = 0; t < 80 && k < 12; t++) begin
            or8 = !(t >= 7 && t < 14);
            iv8 = i < 12;
            if (i < 12) begin mode = pm[i]; a8 = pa[i]; b8 = pb[i]; cin = pc[i]; end
            #1;
            if (!or8) begin
                n_cmp++;
                if (ir8 !== 1'b0 || ov8 !== 1'b1 || {c8, s8} !== 9'(gold(8, pm[k], pa[k], pb[k], pc[k], 0))) begin
                    n_bad++;
                    $display("FAIL bp_stall t=%0d: got ir=%b ov=%b res=%h want ir=0 ov=1 res=%h", t, ir8, ov8,
                             {c8, s8}, 9'(gold(8, pm[k], pa[k], pb[k], pc[k], 0)));
                end
            end else if (ov8) begin
                n_cmp++;
                if ({c8, s8} !== 9'(gold(8, pm[k], pa[k], pb[k], pc[k], 0))) begin
                    n_bad++;
                    $display("FAIL bp_order #%0d: got %h want %h", k, {c8, s8},
                             9'(gold(8, pm[k], pa[k], pb[k], pc[k], 0)));
                end
                k++;
            end
            if (iv8 && ir8) i++;
            tick;
        end
        iv8 = 0; or8 = 1;
        for (int t = 0; t < 8; t++) begin
            if (ov8) extra++;
            tick;
        end
        n_cmp++;
        if (k != 12 || i != 12 || extra != 0) begin
            n_bad++;
            $display("FAIL bp_count: got out=%0d in=%0d extra=%0d want 12/12/0", k, i, extra);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int l = 0;
        logic [8:0] r = '0;
        mode = 0; cin = 0; or8 = 0;
        for (int j = 0; j < 4; j++) begin
            iv8 = 1; a8 = 8'(j + 1); b8 = 8'h10;
            tick;
        end
        iv8 = 0;
        for (int k = 0; k < 10 && !ov8; k++) tick;
        n_cmp++;
        if (ov8 !== 1'b1 || {c8, s8} !== 9'h011) begin
            n_bad++;
            $display("FAIL rst_setup: got ov=%b res=%h want ov=1 res=011", ov8, {c8, s8});
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if (ov8 !== 1'b0 || s8 !== 8'h00 || c8 !== 1'b0 || ir8 !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_async: got ov=%b s=%h c=%b ir=%b want 0/00/0/1", ov8, s8, c8, ir8);
        end
        tick;
        #2 rst = 0;
        or8 = 1;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (ov8) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rst_flush: got %0d stale results want 0", seen);
        end
        mode = 1; a8 = 8'h21; b8 = 8'h12; iv8 = 1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            iv8 = 0;
            if (ov8 && l == 0) begin l = k; r = {c8, s8}; end
        end
        n_cmp++;
        if (l != 5 || r !== 9'h033) begin
            n_bad++;
            $display("FAIL rst_recover: got lat=%0d res=%h want lat=5 res=033", l, r);
        end
    endtask

    task automatic test_exhaustive;
        int q8[$], qz[$], q4a[$], q4b[$], q16[$];
        int ex;
        mode = 1; cin = 1; or8 = 1;
        for (int t = 0; t < 65560; t++) begin
            iv8 = t < 65536; ivz = t < 65536; iv4 = t < 256; iv16 = t < 2000;
            if (t < 65536) begin
                a8 = 8'(t >> 8); b8 = 8'(t);
                q8.push_back(gold(8, 1, a8, b8, 1, 0));
                qz.push_back(gold(8, 1, a8, b8, 1, 1));
            end
            if (t < 256) begin
                a4 = 4'(t >> 4); b4 = 4'(t);
                q4a.push_back(gold(4, 1, a4, b4, 1, 0));
                q4b.push_back(gold(4, 1, a4, b4, 1, 0));
            end
            if (t < 2000) begin
                a16 = 16'($urandom); b16 = (t < 4) ? 16'hFFFF : 16'($urandom);
                q16.push_back(gold(16, 1, a16, b16, 1, 0));
            end
            if (ov8) begin
                n_cmp++;
                ex = q8.size() != 0 ? q8.pop_front() : -1;
                if (int'({c8, s8}) !== ex) begin
                    n_bad++;
                    $display("FAIL exh_n8_pipe t=%0d: got %h want %h", t, {c8, s8}, ex);
                end
            end
            if (ovz) begin
                n_cmp++;
                ex = qz.size() != 0 ? qz.pop_front() : -1;
                if (int'({cz, sz}) !== ex) begin
                    n_bad++;
                    $display("FAIL exh_n8_comb_zn t=%0d: got %h want %h", t, {cz, sz}, ex);
                end
            end
            if (ov4a) begin
                n_cmp++;
                ex = q4a.size() != 0 ? q4a.pop_front() : -1;
                if (int'({c4a, s4a}) !== ex) begin
                    n_bad++;
                    $display("FAIL exh_n4_pipe t=%0d: got %h want %h", t, {c4a, s4a}, ex);
                end
            end
            if (ov4b) begin
                n_cmp++;
                ex = q4b.size() != 0 ? q4b.pop_front() : -1;
                if (int'({c4b, s4b}) !== ex) begin
                    n_bad++;
                    $display("FAIL exh_n4_comb t=%0d: got %h want %h", t, {c4b, s4b}, ex);
                end
            end
            if (ov16) begin
                n_cmp++;
                ex = q16.size() != 0 ? q16.pop_front() : -1;
                if (int'({c16, s16}) !== ex) begin
                    n_bad++;
                    $display("FAIL rnd_n16 t=%0d: got %h want %h", t, {c16, s16}, ex);
                end
            end
            tick;
        end
        iv8 = 0; ivz = 0; iv4 = 0; iv16 = 0;
        n_cmp++;
        if (q8.size() + qz.size() + q4a.size() + q4b.size() + q16.size() != 0) begin
            n_bad++;
            $display("FAIL exh_drain: got %0d/%0d/%0d/%0d/%0d missing want 0", q8.size(), qz.size(),
                     q4a.size(), q4b.size(), q16.size());
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_stream;
        test_backpressure;
        test_reset_mid;
        test_exhaustive;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
